exp_bias_adder: RTL
===================

// Module: exp_bias_adder
// PURPOSE
//   Re-biasing stage for the vector unit FP multiplier exponent path. Takes an
//   unbiased signed exponent plus a normalisation increment, adds the IEEE
//   bias back, and saturates to Inf/zero encodings with overflow/underflow flags.
//   2-stage valid/ready pipeline; counts saturation events for debug/CSR readout.
// PARAMETERS
//   EXP_W  8    biased exponent width (result field width)
//   BIAS   127  exponent bias added back (2**(EXP_W-1)-1)
//   CNT_W  16   width of saturating overflow/underflow event counters
// PORTS
//   clk_i        in   1        clock
//   rst_i        in   1        synchronous reset, active high
//   in_valid_i   in   1        input beat valid
//   in_ready_o   out  1        block can accept a beat this cycle
//   exp_unb_i    in   EXP_W+1  unbiased exponent, two's complement signed
//   norm_inc_i   in   1        mantissa normalisation carry: add +1 to exponent
//   zero_i       in   1        result is exact zero (any operand zero)
//   out_valid_o  out  1        output beat valid
//   out_ready_i  in   1        downstream accepts output beat
//   exp_o        out  EXP_W    biased result exponent
//   ovf_o        out  1        result saturated to all-ones exponent (Inf)
//   unf_o        out  1        result flushed to zero exponent
//   zero_o       out  1        registered copy of zero_i
//   cnt_clr_i    in   1        synchronous clear of both event counters
//   ovf_cnt_o    out  CNT_W    saturating count of ovf_o beats handed off
//   unf_cnt_o    out  CNT_W    saturating count of unf_o beats handed off
// BEHAVIOUR
//   Reset: all pipeline valids, exp_o, ovf_o, unf_o, zero_o, counters -> 0.
//   Reset mid-operation drops in-flight beats; in_ready_o = 1 first cycle after.
//   Handshake: beat transfers on valid&ready at each side. Once asserted,
//   out_valid_o and out data hold stable until out_ready_i. in_valid_i must not
//   depend on in_ready_o combinationally is NOT required (no comb loop inside).
//   Pipeline: S1 registers sum, S2 registers saturated result/flags.
//     adv2 = ~out_valid_o | out_ready_i;  adv1 = ~s1_valid | adv2;
//     in_ready_o = adv1 (combinational from out_ready_i and state).
//   Latency: 2 cycles accept->out_valid_o with no stall; throughput 1 beat/cycle.
//   Full-throughput: simultaneous accept and hand-off in same cycle allowed.
//   Arithmetic (S1): sum = sext(exp_unb_i,EXP_W+2) + norm_inc_i + BIAS, signed
//   EXP_W+2 bits -> no internal wrap for any input.
//   Saturation (S2), priority order:
//     zero      -> exp_o=0, ovf=0, unf=0, zero_o=1
//     sum>=2**EXP_W-1 -> exp_o=all ones, ovf=1
//     sum<=0    -> exp_o=0, unf=1
//     else      -> exp_o=sum[EXP_W-1:0], flags 0
//   Boundaries: sum=2**EXP_W-2 (254) is normal, no flag; sum=1 normal.
//   Counters: increment on out_valid_o&out_ready_i when ovf_o (resp. unf_o);
//   stick at 2**CNT_W-1. cnt_clr_i wins over same-cycle increment -> 0.
// TESTING
//   T1 exp_unb=0, inc=0, out_ready=1 -> 2 cycles later exp_o=127, flags 0.
//   T2 exp_unb=127,inc=0 -> exp_o=254 no flag; exp_unb=127,inc=1 -> exp_o=255,
//      ovf_o=1, ovf_cnt_o 0->1 on hand-off.
//   T3 exp_unb=-127,inc=0 -> exp_o=0, unf_o=1; exp_unb=-127,inc=1 -> exp_o=1 no
//      flag; exp_unb=-256 -> exp_o=0, unf_o=1; zero_i=1,exp_unb=200 -> 0, no flags.
//   T4 back-to-back 0,1,2,3 with out_ready_i low 3 cycles -> in_ready_o drops
//      after 2 accepts; released outputs 127,128,129,130 in order, none lost.
//   T5 force 2**CNT_W+3 overflow beats -> ovf_cnt_o=65535; cnt_clr_i pulse with
//      concurrent ovf hand-off -> 0.
//   T6 rst_i for 1 cycle with 2 beats in flight -> out_valid_o=0 next cycle,
//      counters 0, in_ready_o=1, no stale beat emitted later.

Source files
------------

// File: rtl/exp_bias_adder_if.sv
// Handshake and data bundle for the exponent re-bias stage; slave is the block's view.
// Input side valid/ready, output side valid/ready, plus event counter readout and clear.
interface exp_bias_adder_if #(
  parameter int EXP_W = 8,
  parameter int CNT_W = 16
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [EXP_W:0]   exp_unb_i;
  logic             norm_inc_i;
  logic             zero_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [EXP_W-1:0] exp_o;
  logic             ovf_o;
  logic             unf_o;
  logic             zero_o;
  logic             cnt_clr_i;
  logic [CNT_W-1:0] ovf_cnt_o;
  logic [CNT_W-1:0] unf_cnt_o;

  modport slave (
    input  in_valid_i, exp_unb_i, norm_inc_i, zero_i, out_ready_i, cnt_clr_i,
    output in_ready_o, out_valid_o, exp_o, ovf_o, unf_o, zero_o, ovf_cnt_o, unf_cnt_o
  );

  modport master (
    output in_valid_i, exp_unb_i, norm_inc_i, zero_i, out_ready_i, cnt_clr_i,
    input  in_ready_o, out_valid_o, exp_o, ovf_o, unf_o, zero_o, ovf_cnt_o, unf_cnt_o
  );
endinterface

// File: rtl/exp_bias_adder.sv
// Adds the bias back to an unbiased FP exponent and saturates to Inf/zero with flags.
// Two register stages (sum, then result); stalls propagate back via in_ready_o, 1 beat/cycle.
module exp_bias_adder #(
  parameter int EXP_W = 8,
  parameter int BIAS  = 127,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  exp_bias_adder_if.slave  bus
);
  localparam int SUM_W = EXP_W + 2;
  typedef logic signed [SUM_W-1:0] sum_t;

  localparam sum_t             BIAS_S   = sum_t'(BIAS);
  localparam sum_t             SAT_HI   = sum_t'((2 ** EXP_W) - 1);
  localparam sum_t             SUM_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic             adv1, adv2, handoff;
  sum_t             sum_in;

  logic             s1_valid_q, s1_valid_d;
  sum_t             s1_sum_q, s1_sum_d;
  logic             s1_zero_q, s1_zero_d;

  logic             out_valid_q, out_valid_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             zero_q, zero_d;

  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic [CNT_W-1:0] unf_cnt_q, unf_cnt_d;

  always_comb begin
    adv2    = ~out_valid_q | bus.out_ready_i;
    adv1    = ~s1_valid_q | adv2;
    handoff = out_valid_q & bus.out_ready_i;
    // Two guard bits keep the signed sum exact for every input value.
    sum_in  = sum_t'($signed(bus.exp_unb_i)) + sum_t'({1'b0, bus.norm_inc_i}) + BIAS_S;

    s1_valid_d  = s1_valid_q;
    s1_sum_d    = s1_sum_q;
    s1_zero_d   = s1_zero_q;
    out_valid_d = out_valid_q;
    exp_d       = exp_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    zero_d      = zero_q;
    ovf_cnt_d   = ovf_cnt_q;
    unf_cnt_d   = unf_cnt_q;

    if (adv1) begin
      s1_valid_d = bus.in_valid_i;
      if (bus.in_valid_i) begin
        s1_sum_d  = sum_in;
        s1_zero_d = bus.zero_i;
      end
    end

    if (adv2) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        exp_d  = '0;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        zero_d = s1_zero_q;
        if (s1_zero_q) begin
          exp_d = '0;
        end else if (s1_sum_q >= SAT_HI) begin
          exp_d = '1;
          ovf_d = 1'b1;
        end else if (s1_sum_q <= SUM_ZERO) begin
          unf_d = 1'b1;
        end else begin
          exp_d = s1_sum_q[EXP_W-1:0];
        end
      end
    end

    // Clear takes precedence over an increment landing in the same cycle.
    if (bus.cnt_clr_i) begin
      ovf_cnt_d = '0;
      unf_cnt_d = '0;
    end else begin
      if (handoff && ovf_q && ovf_cnt_q != CNT_MAX) ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
      if (handoff && unf_q && unf_cnt_q != CNT_MAX) unf_cnt_d = unf_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q  <= 1'b0;
      s1_sum_q    <= '0;
      s1_zero_q   <= 1'b0;
      out_valid_q <= 1'b0;
      exp_q       <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      zero_q      <= 1'b0;
      ovf_cnt_q   <= '0;
      unf_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sum_q    <= s1_sum_d;
      s1_zero_q   <= s1_zero_d;
      out_valid_q <= out_valid_d;
      exp_q       <= exp_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      zero_q      <= zero_d;
      ovf_cnt_q   <= ovf_cnt_d;
      unf_cnt_q   <= unf_cnt_d;
    end
  end

  assign bus.in_ready_o  = adv1;
  assign bus.out_valid_o = out_valid_q;
  assign bus.exp_o       = exp_q;
  assign bus.ovf_o       = ovf_q;
  assign bus.unf_o       = unf_q;
  assign bus.zero_o      = zero_q;
  assign bus.ovf_cnt_o   = ovf_cnt_q;
  assign bus.unf_cnt_o   = unf_cnt_q;
endmodule
